gbe_rx_frame_buf_ctrl: RTL and testbench
========================================

Name: gbe_rx_frame_buf_ctrl

Overview:
Frame-store controller behind the GbE RX MAC control FSM. It takes the MAC's byte/end/error strobe interface and writes bytes into an internal byte RAM. On a good frame end it commits the frame; on error, CRC error or overflow it rewinds the write pointer, so no partial or bad frame becomes visible. It presents committed frames on a ready/valid packet interface with SOP/EOP to the downstream 1G/10G adaptation logic, and keeps good/drop frame counters.

Parameters:
ADDR_W, 12, log2 of RAM depth in bytes (DEPTH = 2**ADDR_W)
CNT_W, 16, width of statistics counters

Ports:
clk_i  in  1  single clock for whole block
rst_i  in  1  reset; synchronous, active-high
clk_en_i  in  1  write-side qualifier; write-side state advances only when high
wr_data_i  in  8  frame byte from MAC
wr_en_i  in  1  byte valid (MAC DATA state)
wr_end_i  in  1  frame end strobe
wr_err_i  in  1  with wr_end_i: frame bad (length/PHY error/FIFO-full abort)
crc_err_i  in  1  registered CRC result; sampled with wr_end_i
full_o  out  1  to MAC fifo_full input
rd_data_o  out  8  output byte
rd_valid_o  out  1  output byte valid
rd_sop_o  out  1  first byte of frame
rd_eop_o  out  1  last byte of frame
rd_ready_i  in  1  downstream accept
frm_ok_cnt_o  out  CNT_W  committed frames, wraps
frm_drop_cnt_o  out  CNT_W  discarded frames, wraps

Behaviour:
- Reset values: every output 0; wr_ptr, commit_ptr and rd_ptr 0; staging register empty; overflow flag 0. Reset mid-frame loses any uncommitted data and any unread frames.
- Pointers are ADDR_W+1 bits; used = wr_ptr - rd_ptr (modulo arithmetic). RAM word = 9 bits {eop, byte}.
- Staging register: each accepted byte is held one beat and written to RAM when the next byte arrives. On wr_end_i the held byte is written with eop=1. This is required because the end strobe arrives after the last byte.
- full_o = (used >= DEPTH-1), registered.
- wr_en_i while RAM is full: byte is not written; the frame's overflow flag is set.
- Write FSM states:
  - W_IDLE: on the first wr_en_i, go to W_FRAME; remember frame start = wr_ptr.
  - W_FRAME: on wr_end_i, go to W_IDLE.
  - wr_end_i decision, one cycle:
    - If !wr_err_i, !crc_err_i, no overflow and at least one byte stored: commit_ptr <= wr_ptr + 1 (including the eop byte); frm_ok_cnt_o increments.
    - Otherwise: wr_ptr <= frame start, staging cleared, frm_drop_cnt_o increments.
  - wr_end_i in W_IDLE with no bytes: counted as a drop; no pointer change.
  - Overflow flag is cleared at every end.
- Read side runs every clk_i, independent of clk_en_i.
  - RAM read has 1-cycle latency, into a one-entry show-ahead output register.
  - The register refills when empty, or when consumed (rd_valid_o && rd_ready_i), provided rd_ptr != commit_ptr.
  - Sustained throughput: 1 byte/clock.
  - rd_data_o, rd_valid_o, rd_sop_o and rd_eop_o are held stable while rd_valid_o && !rd_ready_i.
  - rd_sop_o is high on the first byte after reset or after a byte with eop=1.
- Latency: first byte appears on rd_valid_o 2 clk_i after the commit cycle, when the output register is empty.
- Simultaneous commit and read: the reader sees commit_ptr from the next cycle onward. A rewind never moves wr_ptr below commit_ptr.
- Counters wrap silently at 2**CNT_W.

Optional Feature:
RX_FRAME_BUF_STRIP_FCS_EN
- Defined: the staging register becomes a 5-byte shift. Bytes are written to RAM only once 4 newer bytes are held. At end, the oldest staged byte is written with eop=1 and the 4 FCS bytes are discarded. Frames of 4 bytes or fewer are dropped.
- Undefined: the 1-byte staging described above; FCS is delivered downstream.

Test Plan:
- 64-byte good frame (bytes 0x00..0x3F), clean end, rd_ready_i=1 -> 64 bytes out in order, sop on 0x00, eop on 0x3F, frm_ok_cnt_o=1; with STRIP_FCS: 60 bytes, eop on 0x3B.
- 64-byte frame ended with crc_err_i=1, then good 64-byte frame -> only the second frame is output, frm_drop_cnt_o=1, wr_ptr equals the pre-frame value +64.
- ADDR_W=6, rd_ready_i=0, 100-byte frame -> full_o rises at used=63, overflow set, frame dropped, used returns to 0.
- Two back-to-back good frames; rd_ready_i toggles 1/0 every cycle -> data held stable while stalled, exactly one sop and one eop per frame.
- rst_i pulsed mid-frame and mid-read -> all outputs 0 next cycle; new good frame afterwards output intact.
- clk_en_i high 1 of 10 cycles (100M mode) with a 64-byte frame -> identical output to the first scenario, read side unaffected.

Source files
------------

// File: rtl/gbe_rx_frame_buf_ctrl.sv
// GbE RX frame store: stages MAC bytes into a byte RAM, commits good
// frames, rewinds on bad ones, and replays frames with SOP/EOP.
// Ports: clk_i/rst_i (sync, active-high), clk_en_i qualifies the write
// side. wr_* and crc_err_i come from the MAC and full_o goes back to it.
// rd_* is a ready/valid byte stream. frm_ok/drop_cnt_o are stats counters.
// Optional macro RX_FRAME_BUF_STRIP_FCS_EN: hold 5 bytes and drop the
// trailing 4 FCS bytes (frames of 4 bytes or fewer are dropped).
`timescale 1ns/1ps
module gbe_rx_frame_buf_ctrl #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_en_i,
  input  logic [7:0]       wr_data_i,
  input  logic             wr_en_i,
  input  logic             wr_end_i,
  input  logic             wr_err_i,
  input  logic             crc_err_i,
  output logic             full_o,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  output logic             rd_sop_o,
  output logic             rd_eop_o,
  input  logic             rd_ready_i,
  output logic [CNT_W-1:0] frm_ok_cnt_o,
  output logic [CNT_W-1:0] frm_drop_cnt_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int PW    = ADDR_W + 1;
`ifdef RX_FRAME_BUF_STRIP_FCS_EN
  localparam int STG = 5;
`else
  localparam int STG = 1;
`endif

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic {W_IDLE, W_FRAME} wst_t;

  logic [8:0] mem [DEPTH];
  logic [7:0] stg [STG];
  logic [2:0] stg_cnt;
  ptr_t       wr_ptr;
  ptr_t       commit_ptr;
  ptr_t       rd_ptr;
  ptr_t       frm_start;
  ptr_t       used;
  logic       ovf;
  wst_t       st;
  wst_t       st_nx;
  logic       stg_full;
  logic       ram_full;
  logic       push;
  logic       push_wr;
  logic       fin;
  logic       fin_ok;
  logic       mem_we;
  logic [8:0] mem_wd;
  logic [8:0] mem_rd;
  logic       rd_load;
  logic       nxt_sop;

  assign used     = wr_ptr - rd_ptr;
  assign ram_full = used == ptr_t'(DEPTH);
  assign stg_full = stg_cnt == 3'(STG);
  assign fin      = clk_en_i && wr_end_i;
  assign push     = clk_en_i && wr_en_i
                    && !wr_end_i;
  // the oldest staged byte goes to RAM only
  // once a newer byte (or the end) arrives
  assign push_wr  = push && stg_full
                    && !ram_full;
  assign fin_ok   = fin && !wr_err_i
                    && !crc_err_i && !ovf
                    && stg_full && !ram_full;
  assign mem_we   = push_wr || fin_ok;
  assign mem_wd   = {fin_ok, stg[STG-1]};
  assign mem_rd   = mem[rd_ptr[ADDR_W-1:0]];

  always_comb begin
    st_nx = st;
    unique case (st)
      W_IDLE:  if (push) st_nx = W_FRAME;
      W_FRAME: if (fin)  st_nx = W_IDLE;
      default: st_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) st <= W_IDLE;
    else       st <= st_nx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      frm_start      <= '0;
      stg_cnt        <= '0;
      ovf            <= 1'b0;
      frm_ok_cnt_o   <= '0;
      frm_drop_cnt_o <= '0;
    end else begin
      if (push) begin
        if (st == W_IDLE)
          frm_start <= wr_ptr;
        if (!stg_full)
          stg_cnt <= stg_cnt + 3'd1;
        else if (ram_full)
          ovf <= 1'b1;
        else
          wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (fin) begin
        stg_cnt <= '0;
        ovf     <= 1'b0;
        if (fin_ok) begin
          wr_ptr       <= wr_ptr + ptr_t'(1);
          commit_ptr   <= wr_ptr + ptr_t'(1);
          frm_ok_cnt_o <= frm_ok_cnt_o
                          + CNT_W'(1);
        end else begin
          frm_drop_cnt_o <= frm_drop_cnt_o
                            + CNT_W'(1);
          // frm_start is never below commit_ptr
          if (st == W_FRAME)
            wr_ptr <= frm_start;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int i = STG-1; i > 0; i--)
        stg[i] <= stg[i-1];
      stg[0] <= wr_data_i;
    end
    if (mem_we)
      mem[wr_ptr[ADDR_W-1:0]] <= mem_wd;
  end

  // the RAM read register is the show-ahead
  // output stage: reload when empty or taken
  assign rd_load = (rd_ptr != commit_ptr)
                   && (!rd_valid_o
                       || rd_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr     <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      rd_sop_o   <= 1'b0;
      rd_eop_o   <= 1'b0;
      nxt_sop    <= 1'b1;
      full_o     <= 1'b0;
    end else begin
      full_o <= used >= ptr_t'(DEPTH-1);
      if (rd_load) begin
        rd_ptr     <= rd_ptr + ptr_t'(1);
        rd_data_o  <= mem_rd[7:0];
        rd_eop_o   <= mem_rd[8];
        rd_sop_o   <= nxt_sop;
        rd_valid_o <= 1'b1;
        nxt_sop    <= mem_rd[8];
      end else if (rd_valid_o
                   && rd_ready_i) begin
        rd_valid_o <= 1'b0;
        rd_sop_o   <= 1'b0;
        rd_eop_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gbe_rx_frame_buf_ctrl.sv
// Scoreboard bench for gbe_rx_frame_buf_ctrl: a default-size instance
// for data path tests and a 64-byte instance for overflow.
`timescale 1ns/1ps
module tb_gbe_rx_frame_buf_ctrl;

`ifdef RX_FRAME_BUF_STRIP_FCS_EN
  localparam int FCS = 4;
`else
  localparam int FCS = 0;
`endif

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i = 1'b1;
  logic       clk_en = 1'b1;
  logic       small_sel = 1'b0;
  logic [7:0] wr_data_i = '0;
  logic       wr_en_i = 1'b0;
  logic       wr_end_i = 1'b0;
  logic       wr_err_i = 1'b0;
  logic       crc_err_i = 1'b0;
  logic       rd_ready_i = 1'b0;
  logic       rd_ready_s = 1'b0;
  logic       en_m;
  logic       en_s;

  assign en_m = clk_en & ~small_sel;
  assign en_s = clk_en & small_sel;

  logic        full_o, rd_valid_o;
  logic        rd_sop_o, rd_eop_o;
  logic [7:0]  rd_data_o;
  logic [15:0] frm_ok_cnt_o, frm_drop_cnt_o;
  logic        full_s, rd_valid_s;
  logic        rd_sop_s, rd_eop_s;
  logic [7:0]  rd_data_s;
  logic [15:0] ok_s, drop_s;

  gbe_rx_frame_buf_ctrl u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .clk_en_i(en_m),
    .wr_data_i(wr_data_i),
    .wr_en_i(wr_en_i),
    .wr_end_i(wr_end_i),
    .wr_err_i(wr_err_i),
    .crc_err_i(crc_err_i),
    .full_o(full_o),
    .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o),
    .rd_sop_o(rd_sop_o),
    .rd_eop_o(rd_eop_o),
    .rd_ready_i(rd_ready_i),
    .frm_ok_cnt_o(frm_ok_cnt_o),
    .frm_drop_cnt_o(frm_drop_cnt_o)
  );

  gbe_rx_frame_buf_ctrl #(.ADDR_W(6)) u_small (
    .clk_i(clk_i), .rst_i(rst_i),
    .clk_en_i(en_s),
    .wr_data_i(wr_data_i),
    .wr_en_i(wr_en_i),
    .wr_end_i(wr_end_i),
    .wr_err_i(wr_err_i),
    .crc_err_i(crc_err_i),
    .full_o(full_s),
    .rd_data_o(rd_data_s),
    .rd_valid_o(rd_valid_s),
    .rd_sop_o(rd_sop_s),
    .rd_eop_o(rd_eop_s),
    .rd_ready_i(rd_ready_s),
    .frm_ok_cnt_o(ok_s),
    .frm_drop_cnt_o(drop_s)
  );

  int checks = 0;
  int failures = 0;
  int per = 1;
  int rdy_mode = 0;
  int exp_ok = 0;
  int exp_drop = 0;
  logic [9:0]  sb [$];
  logic [10:0] prev = '0;
  logic        pv_stall = 1'b0;
  logic [12:0] pre;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_i); #1;
    case (rdy_mode)
      0:       rd_ready_i = 1'b1;
      1:       rd_ready_i = ~rd_ready_i;
      default: rd_ready_i = 1'b0;
    endcase
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (pv_stall)
        chk("hold", {rd_valid_o, rd_sop_o,
            rd_eop_o, rd_data_o}, prev);
      if (rd_valid_o && rd_ready_i) begin
        if (sb.size() == 0)
          chk("extra_byte", 1, 0);
        else
          chk("rd_byte", {rd_sop_o, rd_eop_o,
              rd_data_o}, sb.pop_front());
      end
      pv_stall <= rd_valid_o && !rd_ready_i;
      prev <= {rd_valid_o, rd_sop_o,
               rd_eop_o, rd_data_o};
    end else begin
      pv_stall <= 1'b0;
    end
  end

  task automatic wbeat(logic en, logic [7:0] d,
                       logic e, logic err,
                       logic crc);
    repeat (per-1) begin
      clk_en = 1'b0;
      @(posedge clk_i); #1;
    end
    clk_en = 1'b1;
    wr_en_i = en; wr_data_i = d;
    wr_end_i = e; wr_err_i = err;
    crc_err_i = crc;
    @(posedge clk_i); #1;
    wr_en_i = 1'b0; wr_end_i = 1'b0;
    wr_err_i = 1'b0; crc_err_i = 1'b0;
  endtask

  task automatic send(int n, int base,
                      logic err, logic crc);
    if (!err && !crc && n > FCS) begin
      for (int i = 0; i < n-FCS; i++)
        sb.push_back({(i == 0),
                      (i == n-FCS-1),
                      8'(base+i)});
      exp_ok++;
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < n; i++)
      wbeat(1'b1, 8'(base+i), 1'b0,
            1'b0, 1'b0);
    wbeat(1'b0, 8'h00, 1'b1, err, crc);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk_i);
      t++;
    end
    chk("drain_left", sb.size(), 0);
    sb.delete();
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic cnt_chk();
    chk("ok_cnt", frm_ok_cnt_o, exp_ok);
    chk("drop_cnt", frm_drop_cnt_o, exp_drop);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_out", {full_o, rd_valid_o,
        rd_sop_o, rd_eop_o, rd_data_o}, 0);
    chk("rst_cnt", {frm_ok_cnt_o,
        frm_drop_cnt_o}, 0);
    chk("rst_small", full_s, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    send(64, 0, 1'b0, 1'b0);
    chk("lat_edge1", rd_valid_o, 0);
    @(posedge clk_i); #1;
    chk("lat_edge2", rd_valid_o, 1);
    drain();
    cnt_chk();

    pre = u_dut.wr_ptr;
    send(64, 'h40, 1'b0, 1'b1);
    chk("rewind", u_dut.wr_ptr, pre);
    send(64, 'h80, 1'b0, 1'b0);
    drain();
    chk("wr_ptr_adv", u_dut.wr_ptr,
        13'(pre + 64 - FCS));
    cnt_chk();

    send(20, 'h10, 1'b1, 1'b0);
    wbeat(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    exp_drop++;
    send(1, 'hAA, 1'b0, 1'b0);
    send(5, 'h30, 1'b0, 1'b0);
    drain();
    cnt_chk();

    rdy_mode = 1;
    send(50, 'h00, 1'b0, 1'b0);
    send(30, 'h90, 1'b0, 1'b0);
    drain();
    rdy_mode = 0;
    cnt_chk();

    per = 10;
    send(64, 0, 1'b0, 1'b0);
    drain();
    per = 1;
    cnt_chk();

    small_sel = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wbeat(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 63 + FCS)
        chk("full_before", full_s, 0);
      if (i == 64 + FCS)
        chk("full_rise", full_s, 1);
    end
    wbeat(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (4) @(posedge clk_i);
    #1;
    small_sel = 1'b0;
    chk("ovf_full_fall", full_s, 0);
    chk("ovf_drop", drop_s, 1);
    chk("ovf_ok", ok_s, 0);
    chk("ovf_used", 7'(u_small.wr_ptr
        - u_small.rd_ptr), 0);
    chk("ovf_out", {rd_valid_s, rd_sop_s,
        rd_eop_s, rd_data_s}, 0);
    cnt_chk();

    rdy_mode = 2;
    send(40, 'h20, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      wbeat(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("stall_valid", rd_valid_o, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    sb.delete();
    exp_ok = 0;
    exp_drop = 0;
    chk("mid_rst_out", {full_o, rd_valid_o,
        rd_sop_o, rd_eop_o, rd_data_o}, 0);
    cnt_chk();
    rst_i = 1'b0;
    rdy_mode = 0;
    @(posedge clk_i); #1;
    send(64, 'h50, 1'b0, 1'b0);
    drain();
    cnt_chk();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
